// File: rtl/interval_meter.sv
// interval_meter: counts qualified ticks between start and stop pulses and
// holds the result until the consumer acknowledges it.
module interval_meter #(
   parameter int WIDTH = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             count_en,
   input  logic             start,
   input  logic             stop,
   input  logic             ack,
   output logic [WIDTH-1:0] value,
   output logic             valid,
   output logic             busy,
   output logic             overflow
);
   typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, HOLD = 2'd2} state_t;
   localparam logic [WIDTH-1:0] MAX = '1;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_cnt, r_value, w_tick;
   logic             r_ovf, w_at_max, w_restart;
   assign w_at_max  = r_cnt == MAX;
   // counter including this cycle's tick, saturating at all-ones
   assign w_tick    = (count_en && !w_at_max) ? r_cnt + WIDTH'(1) : r_cnt;
   assign w_restart = start && (r_state != HOLD || ack);
   always_comb begin
      w_next = IDLE;
      case (r_state)
         IDLE:    w_next = start ? MEASURE : IDLE;
         MEASURE: w_next = (stop && !start) ? HOLD : MEASURE;
         HOLD:    w_next = !ack ? HOLD : (start ? MEASURE : IDLE);
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_value <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_restart) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else if (r_state == MEASURE) begin
            r_cnt <= w_tick;
            if (count_en && w_at_max) r_ovf <= 1'b1;
            if (stop) r_value <= w_tick;
         end
      end
   end
   assign value    = r_value;
   assign overflow = r_ovf;
   assign valid    = r_state == HOLD;
   assign busy     = r_state == MEASURE;
endmodule

// File: tb/tb_interval_meter.sv
// tb_interval_meter: directed vectors with hand-computed expectations for interval_meter.
module tb_interval_meter;
   localparam int WIDTH = 9;
   logic             clock = 1'b0;
   logic             reset, count_en, start, stop, ack;
   logic [WIDTH-1:0] value;
   logic             valid, busy, overflow;
   int               n_checks = 0;
   int               n_errors = 0;
   interval_meter #(.WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset), .count_en(count_en), .start(start),
      .stop(stop), .ack(ack), .value(value), .valid(valid), .busy(busy),
      .overflow(overflow)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step(input logic en, input logic st, input logic sp, input logic ak);
      count_en = en;
      start    = st;
      stop     = sp;
      ack      = ak;
      @(posedge clock);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      ack   = 1'b0;
   endtask
   task automatic outs(input string tag, input int v, input int vl, input int b, input int o);
      check({tag, ".value"}, int'(value), v);
      check({tag, ".valid"}, int'(valid), vl);
      check({tag, ".busy"}, int'(busy), b);
      check({tag, ".overflow"}, int'(overflow), o);
   endtask
   initial begin
      reset = 1'b1; count_en = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
      @(posedge clock); #1;
      step(1, 1, 1, 1);
      outs("reset", 0, 0, 0, 0);
      reset = 1'b0;
      step(1, 0, 1, 1);
      outs("idle_ignore", 0, 0, 0, 0);
      // steady ticks: start edge not counted, stop tick included
      step(1, 1, 0, 0);
      check("steady.busy_after_start", int'(busy), 1);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
      check("steady.valid_before_stop", int'(valid), 0);
      step(1, 0, 1, 0);
      outs("steady", 5, 1, 0, 0);
      step(1, 1, 1, 0);
      outs("hold_ignore", 5, 1, 0, 0);
      step(0, 0, 0, 1);
      outs("ack_idle", 5, 0, 0, 0);
      // sparse ticks, stop on an idle cycle
      step(1, 1, 0, 0);
      for (int i = 0; i < 9; i++) step(i % 2 == 0, 0, 0, 0);
      check("sparse.value_retained", int'(value), 5);
      step(0, 0, 1, 0);
      outs("sparse", 5, 1, 0, 0);
      step(0, 0, 0, 1);
      // saturation at 2^WIDTH-1 with no wrap
      step(1, 1, 0, 0);
      for (int i = 1; i <= 600; i++) begin
         step(1, 0, 0, 0);
         if (i == 511) check("sat.ovf_at_max", int'(overflow), 0);
         if (i == 512) check("sat.ovf_set", int'(overflow), 1);
      end
      step(0, 0, 1, 0);
      outs("sat", 511, 1, 0, 1);
      step(0, 0, 0, 1);
      // restart with simultaneous stop: start wins
      step(1, 1, 0, 0);
      check("restart.ovf_cleared", int'(overflow), 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      step(1, 1, 1, 0);
      outs("restart", 511, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      outs("restart_result", 4, 1, 0, 0);
      // back-to-back: ack with start goes straight to MEASURE
      step(1, 1, 0, 1);
      outs("b2b", 4, 0, 1, 0);
      for (int i = 0; i < 2; i++) step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      outs("b2b_result", 3, 1, 0, 0);
      // reset mid-measurement aborts everything
      step(1, 1, 0, 1);
      step(1, 0, 0, 0);
      reset = 1'b1;
      step(1, 1, 1, 0);
      reset = 1'b0;
      outs("abort", 0, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
